proc_test_sequencer: RTL and testbench

//  Synthesizable self-checking run controller for the singlecycle core.
//  - Resets the core and drives its start PC.
//  - Watches currentpc until each program's end PC is reached, then compares MemtoRegOut against that program's expected value.
//  - Counts passes and enforces a cycle watchdog.
//  - Sits beside the core on FPGA/sim top levels and replaces the per-program checking done by hand in benches.

---
 rtl/proc_test_pkg.sv | 21 ++
 rtl/proc_test_sequencer_test_table.sv | 33 +++
 rtl/proc_test_sequencer.sv | 137 +++++++++++++
 tb/tb_proc_test_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_test_pkg.sv
// Shared types and helpers for the processor test sequencer.
package proc_test_pkg;

  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST,
    ST_RUN,
    ST_DONE
  } state_t;

  // Returns at least 1 so that single-entry configurations still get a usable index width
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/proc_test_sequencer_test_table.sv
// Checkpoint table: per-entry end PC and expected result, with a combinational read port.
module test_table
  import proc_test_pkg::*;
#(
  parameter int NUM_TESTS = 4,
  parameter int DATA_W    = DEF_DATA_W,
  localparam int IDX_W    = clog2(NUM_TESTS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_end_pc,
  input  logic [DATA_W-1:0] wr_expect,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_end_pc,
  output logic [DATA_W-1:0] rd_expect
);

  logic [DATA_W-1:0] end_pc_mem [NUM_TESTS];
  logic [DATA_W-1:0] expect_mem [NUM_TESTS];

  // Contents are deliberately not reset so a table survives a run abort
  always_ff @(posedge clk) begin
    if (we && (int'(wr_idx) < NUM_TESTS)) begin
      end_pc_mem[wr_idx] <= wr_end_pc;
      expect_mem[wr_idx] <= wr_expect;
    end
  end

  assign rd_end_pc = end_pc_mem[rd_idx];
  assign rd_expect = expect_mem[rd_idx];

endmodule

// File: rtl/proc_test_sequencer.sv
// Run controller: resets the core, waits for each checkpoint PC, scores results, enforces a watchdog.
module proc_test_sequencer
  import proc_test_pkg::*;
#(
  parameter int NUM_TESTS    = 4,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int WDOG_W       = 16,
  parameter int WDOG_LIMIT   = 255,
  parameter int RESET_CYCLES = 2,
  localparam int IDX_W       = clog2(NUM_TESTS),
  localparam int CNT_W       = clog2(NUM_TESTS + 1),
  localparam int RST_W       = clog2(RESET_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    start_pc,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [DATA_W-1:0]    cfg_end_pc,
  input  logic [DATA_W-1:0]    cfg_expect,
  input  logic [DATA_W-1:0]    currentpc,
  input  logic [DATA_W-1:0]    memtoreg,
  output logic                 dut_resetl,
  output logic [DATA_W-1:0]    dut_startpc,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     cur_test,
  output logic [NUM_TESTS-1:0] pass_mask,
  output logic [CNT_W-1:0]     pass_count,
  output logic                 all_pass,
  output logic                 wdog_expired
);

  state_t              state, state_n;
  logic [RST_W-1:0]    rst_cnt, rst_cnt_n;
  logic [WDOG_W-1:0]   wdog, wdog_n, wdog_inc;
  logic [IDX_W-1:0]    cur_test_n;
  logic [NUM_TESTS-1:0] pass_mask_n;
  logic [CNT_W-1:0]    pass_count_n;
  logic                wdog_expired_n;
  logic [DATA_W-1:0]   startpc_n;
  logic [DATA_W-1:0]   tbl_end_pc, tbl_expect;
  logic                hit, match;

  test_table #(
    .NUM_TESTS (NUM_TESTS),
    .DATA_W    (DATA_W)
  ) u_table (
    .clk       (clk),
    .we        (cfg_we && !busy),
    .wr_idx    (cfg_idx),
    .wr_end_pc (cfg_end_pc),
    .wr_expect (cfg_expect),
    .rd_idx    (cur_test),
    .rd_end_pc (tbl_end_pc),
    .rd_expect (tbl_expect)
  );

  assign hit      = (currentpc >= tbl_end_pc);
  assign match    = (memtoreg == tbl_expect);
  assign wdog_inc = wdog + WDOG_W'(1);

  always_comb begin
    state_n        = state;
    rst_cnt_n      = rst_cnt;
    wdog_n         = wdog;
    cur_test_n     = cur_test;
    pass_mask_n    = pass_mask;
    pass_count_n   = pass_count;
    wdog_expired_n = wdog_expired;
    startpc_n      = dut_startpc;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n        = ST_RST;
          startpc_n      = start_pc;
          rst_cnt_n      = '0;
          wdog_n         = '0;
          cur_test_n     = '0;
          pass_mask_n    = '0;
          pass_count_n   = '0;
          wdog_expired_n = 1'b0;
        end
      end
      ST_RST: begin
        if (rst_cnt == RST_W'(RESET_CYCLES - 1)) state_n = ST_RUN;
        else rst_cnt_n = rst_cnt + RST_W'(1);
      end
      ST_RUN: begin
        wdog_n = wdog_inc;
        if (hit) begin
          if (match) begin
            pass_mask_n[cur_test] = 1'b1;
            pass_count_n          = pass_count + CNT_W'(1);
          end
          if (cur_test == IDX_W'(NUM_TESTS - 1)) state_n = ST_DONE;
          else cur_test_n = cur_test + IDX_W'(1);
        end
        // A hit in the limit cycle is still scored above before the abort
        if (wdog_inc >= WDOG_W'(WDOG_LIMIT)) begin
          wdog_expired_n = 1'b1;
          state_n        = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rst_cnt      <= '0;
      wdog         <= '0;
      cur_test     <= '0;
      pass_mask    <= '0;
      pass_count   <= '0;
      wdog_expired <= 1'b0;
      dut_startpc  <= '0;
    end else begin
      state        <= state_n;
      rst_cnt      <= rst_cnt_n;
      wdog         <= wdog_n;
      cur_test     <= cur_test_n;
      pass_mask    <= pass_mask_n;
      pass_count   <= pass_count_n;
      wdog_expired <= wdog_expired_n;
      dut_startpc  <= startpc_n;
    end
  end

  assign busy       = (state == ST_RST) || (state == ST_RUN);
  assign done       = (state == ST_DONE);
  assign dut_resetl = (state != ST_RST);
  assign all_pass   = done && (pass_count == CNT_W'(NUM_TESTS));

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Directed bench for proc_test_sequencer with a simple PC+=4 core model beside it.
module tb_proc_test_sequencer;
  import proc_test_pkg::*;

  localparam int NT = 2;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset, start, cfg_we;
  logic [DW-1:0] start_pc, cfg_end_pc, cfg_expect;
  logic [0:0]    cfg_idx;
  logic [DW-1:0] pc = '0;
  logic [DW-1:0] memtoreg;
  logic          dut_resetl, busy, done, all_pass, wdog_expired;
  logic [DW-1:0] dut_startpc;
  logic [0:0]    cur_test;
  logic [NT-1:0] pass_mask;
  logic [1:0]    pass_count;

  logic          stuck;
  logic [DW-1:0] res1;
  int            tests = 0;
  int            failures = 0;
  int            low_cnt, run_cnt, n;

  always #5 clk = ~clk;

  proc_test_sequencer #(
    .NUM_TESTS(NT), .DATA_W(DW), .WDOG_W(16), .WDOG_LIMIT(255), .RESET_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_end_pc(cfg_end_pc), .cfg_expect(cfg_expect),
    .currentpc(pc), .memtoreg(memtoreg),
    .dut_resetl(dut_resetl), .dut_startpc(dut_startpc), .busy(busy), .done(done),
    .cur_test(cur_test), .pass_mask(pass_mask), .pass_count(pass_count),
    .all_pass(all_pass), .wdog_expired(wdog_expired)
  );

  // Core stand-in: loads startpc while held in reset, then advances 4 per cycle
  always @(posedge clk) begin
    if (!dut_resetl) pc <= dut_startpc;
    else if (!stuck) pc <= pc + 64'd4;
  end

  assign memtoreg = (pc >= 64'h60) ? res1 : (pc >= 64'h30) ? 64'hF : 64'h0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_start(input logic [DW-1:0] pc_val);
    start_pc = pc_val;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic cfg_write(input logic [0:0] idx, input logic [DW-1:0] epc, input logic [DW-1:0] exp);
    cfg_idx    = idx;
    cfg_end_pc = epc;
    cfg_expect = exp;
    cfg_we     = 1'b1;
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 400) begin
      tick();
      k++;
    end
    check({tag, "_done_reached"}, 64'(done), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cur_test"}, 64'(cur_test), 64'd0);
    check({tag, "_pass_mask"}, 64'(pass_mask), 64'd0);
    check({tag, "_pass_count"}, 64'(pass_count), 64'd0);
    check({tag, "_wdog_expired"}, 64'(wdog_expired), 64'd0);
    check({tag, "_dut_resetl"}, 64'(dut_resetl), 64'd1);
    check({tag, "_dut_startpc"}, dut_startpc, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    start_pc = '0; cfg_end_pc = '0; cfg_expect = '0;
    stuck = 1'b0; res1 = 64'h123456789abcdef0;
    @(negedge clk);
    tick();
    tick();
    check_reset_values("por");
    reset = 1'b0;

    cfg_write(1'b0, 64'h30, 64'hF);
    cfg_write(1'b1, 64'h60, 64'h123456789abcdef0);

    // All checkpoints pass
    apply_start(64'h0);
    wait_done("t1");
    check("t1_pass_mask", 64'(pass_mask), 64'b11);
    check("t1_pass_count", 64'(pass_count), 64'd2);
    check("t1_all_pass", 64'(all_pass), 64'd1);
    check("t1_wdog_expired", 64'(wdog_expired), 64'd0);
    check("t1_cur_test", 64'(cur_test), 64'd1);

    // Wrong result at the second checkpoint
    res1 = 64'h0;
    apply_start(64'h0);
    wait_done("t2");
    check("t2_pass_mask", 64'(pass_mask), 64'b01);
    check("t2_pass_count", 64'(pass_count), 64'd1);
    check("t2_all_pass", 64'(all_pass), 64'd0);
    check("t2_wdog_expired", 64'(wdog_expired), 64'd0);
    res1 = 64'h123456789abcdef0;

    // Stuck PC trips the watchdog after exactly 255 RUN cycles
    stuck = 1'b1;
    apply_start(64'h10);
    run_cnt = 0;
    n = 0;
    while (!done && n < 1000) begin
      if (busy && dut_resetl) run_cnt++;
      tick();
      n++;
    end
    check("t3_done_reached", 64'(done), 64'd1);
    check("t3_run_cycles", 64'(run_cnt), 64'd255);
    check("t3_wdog_expired", 64'(wdog_expired), 64'd1);
    check("t3_pass_mask", 64'(pass_mask), 64'd0);
    check("t3_pass_count", 64'(pass_count), 64'd0);
    stuck = 1'b0;

    // Reset in the middle of a run, then rerun the retained table
    apply_start(64'h0);
    repeat (5) tick();
    check("t5_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check_reset_values("t5");
    reset = 1'b0;
    apply_start(64'h0);
    wait_done("t5_rerun");
    check("t5_rerun_pass_mask", 64'(pass_mask), 64'b11);
    check("t5_rerun_all_pass", 64'(all_pass), 64'd1);

    // start and cfg_we during RUN are ignored
    apply_start(64'h0);
    repeat (4) tick();
    start      = 1'b1;
    cfg_we     = 1'b1;
    cfg_idx    = 1'b0;
    cfg_end_pc = 64'h1000;
    cfg_expect = 64'h0;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    check("t6_still_running", 64'(dut_resetl), 64'd1);
    check("t6_busy", 64'(busy), 64'd1);
    wait_done("t6");
    check("t6_pass_mask", 64'(pass_mask), 64'b11);
    check("t6_pass_count", 64'(pass_count), 64'd2);

    // start from DONE clears the previous results
    apply_start(64'h0);
    check("t6_restart_done", 64'(done), 64'd0);
    check("t6_restart_mask", 64'(pass_mask), 64'd0);
    check("t6_restart_count", 64'(pass_count), 64'd0);
    check("t6_restart_busy", 64'(busy), 64'd1);
    wait_done("t6_rerun");
    check("t6_rerun_pass_mask", 64'(pass_mask), 64'b11);

    // Core reset window and startpc from a high start address
    apply_start(64'h100);
    low_cnt = 0;
    check("t4_dut_startpc", dut_startpc, 64'h100);
    for (int i = 0; i < 4; i++) begin
      if (!dut_resetl) low_cnt++;
      check("t4_busy", 64'(busy), 64'd1);
      if (i < 3) tick();
    end
    check("t4_resetl_low_cycles", 64'(low_cnt), 64'd2);
    tick();
    check("t4_done", 64'(done), 64'd1);
    check("t4_pass_mask", 64'(pass_mask), 64'b10);
    check("t4_pass_count", 64'(pass_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
